// File: rtl/cluster_pwr_seq_pkg.sv
// Shared types and defaults for the cluster power/clock/reset sequencer.
package cluster_pwr_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_PWR_UP     = 3'd1,
        ST_CLK_UP     = 3'd2,
        ST_RST_REL    = 3'd3,
        ST_RUN        = 3'd4,
        ST_DRAIN      = 3'd5,
        ST_RST_ASSERT = 3'd6,
        ST_CLK_DN     = 3'd7
    } state_e;

    localparam int PWR_SETTLE_DEF = 16;
    localparam int CLK_SETTLE_DEF = 4;
    localparam int RST_HOLD_DEF   = 8;
    localparam int CNT_WIDTH_DEF  = 8;
    localparam int TIMEOUT_DEF    = 1024;

    localparam logic CMD_OFF = 1'b0;
    localparam logic CMD_ON  = 1'b1;

endpackage

// File: rtl/cluster_pwr_seq_sync.sv
// Two-flop synchroniser for the asynchronous cluster busy indication.
module cluster_pwr_seq_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic s1_q, s2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/cluster_pwr_seq.sv
// Cluster power/clock/reset sequencer; define CLUSTER_PWR_SEQ_TIMEOUT_EN
// to bound the drain wait by TIMEOUT_CYCLES and report it on timeout_o.
module cluster_pwr_seq
    import cluster_pwr_seq_pkg::*;
#(
    parameter int PWR_SETTLE_CYCLES = PWR_SETTLE_DEF,
    parameter int CLK_SETTLE_CYCLES = CLK_SETTLE_DEF,
    parameter int RST_HOLD_CYCLES   = RST_HOLD_DEF,
    parameter int CNT_WIDTH         = CNT_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES    = TIMEOUT_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_on_i,
    input  logic [63:0] boot_addr_i,
    input  logic        byp_i,
    input  logic        cluster_busy_i,
    output logic        cluster_pow_o,
    output logic        cluster_byp_o,
    output logic        cluster_clk_en_o,
    output logic        cluster_rstn_o,
    output logic        cluster_fetch_enable_o,
    output logic [63:0] cluster_boot_addr_o,
    output logic [2:0]  state_o,
    output logic        done_o,
    output logic        timeout_o
);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 busy_s, accept, redundant, latch, drain_expired;
    logic                 pow_q, pow_d, clk_en_q, clk_en_d, rstn_q, rstn_d;
    logic                 fe_q, fe_d, ready_q, ready_d, done_q, done_d;
    logic                 byp_q, byp_d;
    logic [63:0]          boot_q, boot_d;

    cluster_pwr_seq_sync u_busy_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (cluster_busy_i),
        .q_o    (busy_s)
    );

    assign accept    = cmd_valid_i && ready_q;
    assign redundant = accept && ((state_q == ST_RUN && cmd_on_i == CMD_ON) ||
                                  (state_q == ST_OFF && cmd_on_i == CMD_OFF));
    assign latch     = accept && state_q == ST_OFF && cmd_on_i == CMD_ON;

    // Counter value loaded on entry so each timed state lasts exactly N cycles.
    function automatic logic [CNT_WIDTH-1:0] load_val(input state_e s);
        case (s)
            ST_PWR_UP:               load_val = CNT_WIDTH'(PWR_SETTLE_CYCLES - 1);
            ST_CLK_UP, ST_CLK_DN:    load_val = CNT_WIDTH'(CLK_SETTLE_CYCLES - 1);
            ST_RST_REL, ST_RST_ASSERT: load_val = CNT_WIDTH'(RST_HOLD_CYCLES - 1);
            default:                 load_val = '0;
        endcase
    endfunction

`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
    localparam int DW = $clog2(TIMEOUT_CYCLES + 1);
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          timeout_q, timeout_d;

    assign drain_expired = busy_s && (dcnt_q == DW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        dcnt_d    = '0;
        timeout_d = timeout_q;
        if (state_q == ST_DRAIN && busy_s) dcnt_d = dcnt_q + 1'b1;
        if (accept && cmd_on_i == CMD_ON) timeout_d = 1'b0;
        if (state_q == ST_DRAIN && drain_expired) timeout_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dcnt_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            dcnt_q    <= dcnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign drain_expired = 1'b0;
    assign timeout_o     = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            pow_q    <= 1'b0;
            clk_en_q <= 1'b0;
            rstn_q   <= 1'b0;
            fe_q     <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            byp_q    <= 1'b0;
            boot_q   <= 64'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pow_q    <= pow_d;
            clk_en_q <= clk_en_d;
            rstn_q   <= rstn_d;
            fe_q     <= fe_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            byp_q    <= byp_d;
            boot_q   <= boot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:        if (accept && cmd_on_i == CMD_ON) state_d = ST_PWR_UP;
            ST_PWR_UP:     if (cnt_q == '0) state_d = ST_CLK_UP;
            ST_CLK_UP:     if (cnt_q == '0) state_d = ST_RST_REL;
            ST_RST_REL:    if (cnt_q == '0) state_d = ST_RUN;
            ST_RUN:        if (accept && cmd_on_i == CMD_OFF) state_d = ST_DRAIN;
            ST_DRAIN:      if (!busy_s || drain_expired) state_d = ST_RST_ASSERT;
            ST_RST_ASSERT: if (cnt_q == '0) state_d = ST_CLK_DN;
            ST_CLK_DN:     if (cnt_q == '0) state_d = ST_OFF;
            default:       state_d = ST_OFF;
        endcase
        cnt_d = cnt_q;
        if (state_d != state_q)  cnt_d = load_val(state_d);
        else if (cnt_q != '0)    cnt_d = cnt_q - 1'b1;
    end

    // Outputs are decoded from the next state so they change with the state register.
    always_comb begin
        pow_d    = state_d != ST_OFF;
        clk_en_d = state_d inside {ST_CLK_UP, ST_RST_REL, ST_RUN, ST_DRAIN, ST_RST_ASSERT};
        rstn_d   = state_d inside {ST_RST_REL, ST_RUN, ST_DRAIN};
        fe_d     = state_d == ST_RUN;
        ready_d  = state_d inside {ST_OFF, ST_RUN};
        done_d   = (state_q == ST_RST_REL && state_d == ST_RUN) ||
                   (state_q == ST_CLK_DN && state_d == ST_OFF) || redundant;
        byp_d    = latch ? byp_i : byp_q;
        boot_d   = latch ? boot_addr_i : boot_q;
    end

    assign cmd_ready_o            = ready_q;
    assign cluster_pow_o          = pow_q;
    assign cluster_byp_o          = byp_q;
    assign cluster_clk_en_o       = clk_en_q;
    assign cluster_rstn_o         = rstn_q;
    assign cluster_fetch_enable_o = fe_q;
    assign cluster_boot_addr_o    = boot_q;
    assign state_o                = state_q;
    assign done_o                 = done_q;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Self-checking bench for cluster_pwr_seq: elapsed-time reference model plus directed and random stimulus.
module tb_cluster_pwr_seq;
    localparam int P = 16, C = 4, R = 8;
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif
    localparam int M_OFF = 0, M_UP = 1, M_RUN = 2, M_DRAIN = 3, M_DOWN = 4;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        valid = 1'b0, on = 1'b0, byp = 1'b0, busy = 1'b0;
    logic [63:0] boot = 64'h0;
    logic        ready, pow, byp_o, clk_en, rstn, fe, done, tmo;
    logic [63:0] boot_o;
    logic [2:0]  state;

    always #5 clk = ~clk;

    cluster_pwr_seq #(
        .PWR_SETTLE_CYCLES(P), .CLK_SETTLE_CYCLES(C), .RST_HOLD_CYCLES(R),
        .CNT_WIDTH(8), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(valid), .cmd_ready_o(ready),
        .cmd_on_i(on), .boot_addr_i(boot), .byp_i(byp), .cluster_busy_i(busy),
        .cluster_pow_o(pow), .cluster_byp_o(byp_o), .cluster_clk_en_o(clk_en),
        .cluster_rstn_o(rstn), .cluster_fetch_enable_o(fe),
        .cluster_boot_addr_o(boot_o), .state_o(state), .done_o(done), .timeout_o(tmo)
    );

    int tests = 0, fails = 0, cyc = 0;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30) $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a phase plus the cycle it began; outputs follow from elapsed time.
    int          mode = M_OFF, t0 = 0;
    logic        m_done = 1'b0, m_to = 1'b0, m_byp = 1'b0, b1 = 1'b0, b2 = 1'b0;
    logic [63:0] m_boot = 64'h0;

    always @(negedge clk) begin
        int e;
        logic [2:0] es;
        logic ep, ec, er, ef, erdy, acc, nd;
        if (!rst_n) begin
            mode = M_OFF; m_done = 1'b0; m_to = 1'b0; m_byp = 1'b0;
            m_boot = 64'h0; b1 = 1'b0; b2 = 1'b0;
        end
        e = cyc - t0;
        es = 3'd0; ep = 1'b1; ec = 1'b1; er = 1'b1; ef = 1'b0;
        case (mode)
            M_OFF:   begin ep = 1'b0; ec = 1'b0; er = 1'b0; end
            M_UP:    begin es = (e < P) ? 3'd1 : (e < P + C) ? 3'd2 : 3'd3;
                           ec = (e >= P); er = (e >= P + C); end
            M_RUN:   begin es = 3'd4; ef = 1'b1; end
            M_DRAIN: es = 3'd5;
            default: begin es = (e < R) ? 3'd6 : 3'd7; ec = (e < R); er = 1'b0; end
        endcase
        erdy = (mode == M_OFF) || (mode == M_RUN);
        check("cycle_outputs",
              {5'd0, state, pow, byp_o, clk_en, rstn, fe, ready, done, tmo, boot_o},
              {5'd0, es, ep, m_byp, ec, er, ef, erdy, m_done, m_to, m_boot});
        if (rst_n) begin
            acc = valid && erdy;
            nd = 1'b0;
            case (mode)
                M_OFF: if (acc) begin
                    if (on) begin mode = M_UP; t0 = cyc + 1; m_boot = boot; m_byp = byp; end
                    else nd = 1'b1;
                end
                M_UP:  if (cyc + 1 - t0 == P + C + R) begin mode = M_RUN; nd = 1'b1; end
                M_RUN: if (acc) begin
                    if (on) nd = 1'b1;
                    else begin mode = M_DRAIN; t0 = cyc + 1; end
                end
                M_DRAIN: begin
                    if (!b2) begin mode = M_DOWN; t0 = cyc + 1; end
`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
                    else if (cyc - t0 + 1 >= TO) begin mode = M_DOWN; t0 = cyc + 1; m_to = 1'b1; end
`endif
                end
                default: if (cyc + 1 - t0 == R + C) begin mode = M_OFF; nd = 1'b1; end
            endcase
            if (acc && on) m_to = 1'b0;
            m_done = nd;
            b2 = b1;
            b1 = busy;
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic o, input logic [63:0] a, input logic b);
        valid = 1'b1; on = o; boot = a; byp = b;
        step();
        valid = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int maxc, input string nm);
        int n;
        n = 0;
        while (state !== s && n < maxc) begin step(); n++; end
        check(nm, {77'd0, state}, {77'd0, s});
    endtask

    initial begin
        int n, t_pow, t_clk, t_rst, t_fe, t_done;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("reset_vals", {5'd0, state, pow, byp_o, clk_en, rstn, fe, ready, done, tmo, boot_o},
              {5'd0, 3'd0, 8'b0000_0100, 64'h0});

        // Power-up latency from the accept cycle.
        cmd(1'b1, 64'h1C00_8080, 1'b0);
        t_pow = -1; t_clk = -1; t_rst = -1; t_fe = -1; t_done = -1;
        for (n = 1; n <= 40; n++) begin
            if (pow && t_pow < 0) t_pow = n;
            if (clk_en && t_clk < 0) t_clk = n;
            if (rstn && t_rst < 0) t_rst = n;
            if (done && t_done < 0) t_done = n;
            if (fe) begin t_fe = n; break; end
            step();
        end
        check("lat_pow", 80'(t_pow), 80'd1);
        check("lat_clk_en", 80'(t_clk), 80'd17);
        check("lat_rstn", 80'(t_rst), 80'd21);
        check("lat_fetch", 80'(t_fe), 80'd29);
        check("lat_done", 80'(t_done), 80'd29);
        check("boot_addr", {16'd0, boot_o}, {16'd0, 64'h1C00_8080});

        // Power-down with the cluster busy for 50 cycles.
        busy = 1'b1;
        repeat (3) step();
        cmd(1'b0, 64'h0, 1'b0);
        check("fetch_drop", {79'd0, fe}, 80'd0);
        repeat (50) step();
        check("drain_hold", {77'd0, state}, 80'd5);
        busy = 1'b0;
        n = 0;
        while (state !== 3'd6 && n < 10) begin step(); n++; end
        tests++;
        if (n < 2 || n > 3) begin
            fails++;
            $display("FAIL drain_exit_delay: got %0d cycles expected 2..3", n);
        end
        wait_state(3'd0, 40, "down_to_off");
        check("off_entry", {77'd0, pow, done, rstn}, 80'b010);

        // Command held during power-up, then accepted as redundant in RUN.
        valid = 1'b1; on = 1'b1; boot = 64'hAAAA_0000_0000_1000; byp = 1'b1;
        step();
        boot = 64'h5555_0000_0000_2000; byp = 1'b0;
        check("ready_held", {79'd0, ready}, 80'd0);
        n = 0;
        while (!fe && n < 40) begin step(); n++; end
        step();
        valid = 1'b0;
        check("redundant_on", {15'd0, done, byp_o, boot_o}, {15'd0, 1'b1, 1'b1, 64'hAAAA_0000_0000_1000});
        cmd(1'b0, 64'h0, 1'b0);
        wait_state(3'd0, 60, "back_off");

        // Asynchronous reset in CLK_UP.
        cmd(1'b1, 64'h1234, 1'b1);
        wait_state(3'd2, 30, "reach_clk_up");
        #2 rst_n = 1'b0;
        #1 check("async_reset", {5'd0, state, pow, byp_o, clk_en, rstn, fe, ready, done, tmo, boot_o},
                 {5'd0, 3'd0, 8'b0000_0100, 64'h0});
        step(); step();
        rst_n = 1'b1;
        step();

        // Off command while already off.
        cmd(1'b0, 64'h0, 1'b0);
        check("redundant_off", {76'd0, state, done}, {76'd0, 3'd0, 1'b1});
        step();
        check("redundant_off_once", {79'd0, done}, 80'd0);

`ifdef CLUSTER_PWR_SEQ_TIMEOUT_EN
        busy = 1'b1;
        cmd(1'b1, 64'h77, 1'b0);
        wait_state(3'd4, 40, "to_run");
        cmd(1'b0, 64'h0, 1'b0);
        n = 0;
        while (state !== 3'd6 && n < 40) begin step(); n++; end
        check("timeout_drain_len", 80'(n), 80'(TO));
        check("timeout_flag", {79'd0, tmo}, 80'd1);
        wait_state(3'd0, 40, "timeout_off");
        busy = 1'b0;
        cmd(1'b1, 64'h88, 1'b0);
        check("timeout_clear", {79'd0, tmo}, 80'd0);
        wait_state(3'd4, 40, "to_run2");
        cmd(1'b0, 64'h0, 1'b0);
        wait_state(3'd0, 40, "off2");
`endif

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            valid = ($urandom_range(0, 3) == 0);
            on = $urandom_range(0, 1) == 1;
            boot = {$urandom, $urandom};
            byp = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 15) == 0) busy = ~busy;
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        valid = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
